// File: rtl/keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scanner
//
// Scans a ROWS x COLS key matrix one column at a time. Each column is driven
// for SCAN_CYCLES clocks. On the last clock of a column the synchronised row
// lines are sampled. A closed key is then filtered for DEBOUNCE_CNT clocks
// before it is accepted. Release is filtered the same way. One shared counter
// provides both the scan dwell and the debounce windows.
//
// Ports
//   clock        system clock, all logic on the rising edge
//   reset        asynchronous, active-high, clears all state
//   row_in       raw row lines, active-high, asynchronous to clock
//   col_out      one-hot active-high column drive
//   key_code     row_idx*COLS + col_idx of the current or last accepted key
//   key_valid    one-cycle pulse when a debounced press is accepted
//   key_release  one-cycle pulse when a debounced release is accepted
//   key_held     level, high while a debounced key is down
//
// Build option
//   KEY_REPEAT_EN  When defined, a held key re-pulses key_valid. The first
//                  repeat comes after REPEAT_DELAY clocks in DOWN. Later
//                  repeats come every REPEAT_PERIOD clocks. When the macro is
//                  undefined, no repeat logic is built.
// -----------------------------------------------------------------------------
module keypad_matrix_scanner #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_CYCLES   = 1000,
  parameter int DEBOUNCE_CNT  = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ROWS-1:0]              row_in,
  output logic [COLS-1:0]              col_out,
  output logic [$clog2(ROWS*COLS)-1:0] key_code,
  output logic                         key_valid,
  output logic                         key_release,
  output logic                         key_held
);

  localparam int KW      = $clog2(ROWS * COLS);
  localparam int CIW     = $clog2(COLS);
  localparam int RIW     = $clog2(ROWS);
  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CNT) ? SCAN_CYCLES : DEBOUNCE_CNT;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [COLS-1:0] COL_FIRST = COLS'(1);

  typedef enum logic [1:0] {
    S_SCAN    = 2'd0,
    S_FILTER0 = 2'd1,
    S_DOWN    = 2'd2,
    S_FILTER1 = 2'd3
  } state_t;

  // Synchroniser stages. r_rs is the only view of the rows the FSM uses.
  logic [ROWS-1:0] r_sync1;
  logic [ROWS-1:0] r_rs;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [CIW-1:0]  r_col_idx;
  logic [RIW-1:0]  r_row_idx;
  logic [COLS-1:0] r_col_out;
  logic [KW-1:0]   r_key_code;
  logic            r_key_valid;
  logic            r_key_release;
  logic            r_key_held;

  logic            w_scan_done;
  logic            w_filt_done;
  logic            w_row_hit;
  logic [CIW-1:0]  w_col_next;
  logic [RIW-1:0]  w_low_row;
  logic [KW-1:0]   w_code;

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_phase;  // 0: waiting for the first repeat, 1: periodic
  logic          w_rep_fire;

  assign w_rep_fire = r_rep_phase ? (r_rep_cnt == RW'(REPEAT_PERIOD - 1))
                                  : (r_rep_cnt == RW'(REPEAT_DELAY - 1));
`endif

  // Marker block that appears only in an out-of-range configuration. This
  // keeps every parameter referenced in both builds.
  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SCAN_CYCLES < 3 ||
      DEBOUNCE_CNT < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_out_of_range
  end

  assign w_scan_done = (r_cnt == CW'(SCAN_CYCLES - 1));
  assign w_filt_done = (r_cnt == CW'(DEBOUNCE_CNT - 1));
  assign w_row_hit   = r_rs[r_row_idx];
  assign w_col_next  = (r_col_idx == CIW'(COLS - 1)) ? '0 : r_col_idx + 1'b1;
  assign w_code      = KW'(int'(r_row_idx) * COLS + int'(r_col_idx));

  // Lowest-index set row wins when several keys share the column. The loop
  // runs downward, so the last assignment made is the lowest index.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_low_row unassigned (no latch).
    w_low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (r_rs[i]) w_low_row = RIW'(i);
    end
  end

  // Two-flop synchroniser for the asynchronous row lines.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_rs    <= '0;
    end else begin
      // NOTE: non-blocking assignments, so r_rs takes the old r_sync1 (a true two-stage shift).
      r_sync1 <= row_in;
      r_rs    <= r_sync1;
    end
  end

  // Scan and debounce FSM. All outputs are registered here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_SCAN;
      r_cnt         <= '0;
      r_col_idx     <= '0;
      r_row_idx     <= '0;
      r_col_out     <= COL_FIRST;
      r_key_code    <= '0;
      r_key_valid   <= 1'b0;
      r_key_release <= 1'b0;
      r_key_held    <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rep_cnt     <= '0;
      r_rep_phase   <= 1'b0;
`endif
    end else begin
      // Pulses default low and are raised for a single cycle below.
      r_key_valid   <= 1'b0;
      r_key_release <= 1'b0;

      case (r_state)
        S_SCAN: begin
          if (w_scan_done) begin
            r_cnt <= '0;
            if (r_rs == '0) begin
              r_col_idx <= w_col_next;
              r_col_out <= COL_FIRST << w_col_next;
            end else begin
              r_row_idx <= w_low_row;
              r_state   <= S_FILTER0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_FILTER0: begin
          if (w_filt_done) begin
            r_cnt <= '0;
            if (w_row_hit) begin
              r_state     <= S_DOWN;
              r_key_valid <= 1'b1;
              r_key_held  <= 1'b1;
              r_key_code  <= w_code;
            end else begin
              // The closure did not last the whole window. Skip this column.
              r_state   <= S_SCAN;
              r_col_idx <= w_col_next;
              r_col_out <= COL_FIRST << w_col_next;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DOWN: begin
          // Only the latched row/column is watched. Other keys are ignored.
          if (!w_row_hit) begin
            r_state <= S_FILTER1;
            r_cnt   <= '0;
`ifdef KEY_REPEAT_EN
            // If a bounce returns us to DOWN, the repeat timing restarts
            // from zero.
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
`endif
          end
`ifdef KEY_REPEAT_EN
          else if (w_rep_fire) begin
            r_key_valid <= 1'b1;
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b1;
          end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
`endif
        end

        S_FILTER1: begin
          if (w_filt_done) begin
            r_cnt <= '0;
            if (!w_row_hit) begin
              r_state       <= S_SCAN;
              r_key_release <= 1'b1;
              r_key_held    <= 1'b0;
              r_col_idx     <= w_col_next;
              r_col_out     <= COL_FIRST << w_col_next;
            end else begin
              // Release bounce: the key is still down, so return without a pulse.
              r_state <= S_DOWN;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_SCAN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign col_out     = r_col_out;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_release = r_key_release;
  assign key_held    = r_key_held;

endmodule
